display_scan: RTL and testbench

Sequential driver for the 4-digit multiplexed 7-segment display. It produces the active-high one-hot digit-select vector (`indicador`) that the downstream inversion stage turns into active-low anode enables. It also presents the 4-bit BCD value for the selected digit to the segment decoder. Digit data is latched once per frame so the display never tears. Optional blanking is supported per digit and for leading zeros.

---
 rtl/display_pkg.sv | 46 ++++
 rtl/scan_prescaler.sv | 38 +++
 rtl/display_scan.sv | 102 ++++++++++
 tb/tb_display_scan.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// display_pkg
// Shared definitions for the 4-digit multiplexed 7-segment scan driver:
// digit count, BCD width, the one-hot digit-select table, the scan state
// type and small helpers for pulling nibbles out of the latched frame and
// for deciding leading-zero suppression.
package display_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int BCD_W      = 4;

    localparam logic [NUM_DIGITS-1:0] SEL_OFF = 4'b0000;

    // Digit 0 is the leftmost digit and owns the MSB of the select vector.
    localparam logic [NUM_DIGITS-1:0] SEL [NUM_DIGITS] =
        '{4'b1000, 4'b0100, 4'b0010, 4'b0001};

    typedef enum logic {
        ST_IDLE,
        ST_SCAN
    } scan_state_t;

    // Digit 0 lives in frame[15:12], digit 3 in frame[3:0].
    function automatic logic [BCD_W-1:0] digit_nibble(
        input logic [NUM_DIGITS*BCD_W-1:0] frame,
        input logic [1:0]                  k
    );
        return frame[(3 - int'(k)) * BCD_W +: BCD_W];
    endfunction

    // A digit left of the last one is dark when it and every digit to its
    // left are zero. The rightmost digit always shows, so "0" stays visible.
    function automatic logic lz_dark(
        input logic [NUM_DIGITS*BCD_W-1:0] frame,
        input logic [1:0]                  k
    );
        logic dark;
        dark = (k != 2'd3);
        for (int i = 0; i < NUM_DIGITS - 1; i++) begin
            if (i <= int'(k) && digit_nibble(frame, 2'(i)) != '0) begin
                dark = 1'b0;
            end
        end
        return dark;
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// scan_prescaler
// Divides the system clock into the per-digit dwell time. While run is
// high the counter walks 0 .. CLK_DIV-1 and wraps; tick marks the last
// cycle of each dwell so the scanner advances on the following edge.
// Dropping run parks the counter at zero so a restart gets a full slot.
//   clk   : system clock
//   reset : synchronous, active-high
//   run   : count enable
//   tick  : high while cnt == CLK_DIV-1 and run is high
module scan_prescaler #(
    parameter int CLK_DIV = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic tick
);

    localparam int                CNT_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    // Free-running dwell counter; it only moves while the scan is running
    // and is held at zero otherwise.
    always_ff @(posedge clk) begin
        if (reset || !run) begin
            cnt <= '0;
        end else if (cnt == CNT_MAX) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tick = run && (cnt == CNT_MAX);

endmodule

// File: rtl/display_scan.sv
// display_scan
// Multiplexed 4-digit 7-segment scan driver. Selects one digit at a time
// for CLK_DIV cycles, presents that digit's BCD nibble, and latches the
// whole 16-bit value once per frame so the display never tears.
//   clk         : system clock
//   reset       : synchronous, active-high
//   enable      : 1 = scanning, 0 = all digits dark
//   digits      : BCD value, digits[15:12] = digit 0 (leftmost)
//   blank       : per-digit force-dark, blank[3] = digit 0
//   indicador   : one-hot active-high digit select (0000 = none lit)
//   digit_value : BCD nibble of the selected digit
//   frame_start : one-cycle pulse when digit 0 begins a frame
module display_scan
    import display_pkg::*;
#(
    parameter int CLK_DIV  = 50000,
    parameter bit LZ_BLANK = 1'b0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [NUM_DIGITS*BCD_W-1:0] digits,
    input  logic [NUM_DIGITS-1:0]     blank,
    output logic [NUM_DIGITS-1:0]     indicador,
    output logic [BCD_W-1:0]          digit_value,
    output logic                      frame_start
);

    scan_state_t                 state;
    logic [1:0]                  idx;
    logic [NUM_DIGITS*BCD_W-1:0] shadow;
    logic                        run;
    logic                        tick;

    logic [1:0]                  next_idx;
    logic [NUM_DIGITS*BCD_W-1:0] next_shadow;
    logic                        next_fs;
    logic                        next_dark;

    // The prescaler only counts once the scan is up and enable is still
    // high, so the disabling edge also clears the dwell counter.
    assign run = (state == ST_SCAN) && enable;

    scan_prescaler #(
        .CLK_DIV (CLK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .run   (run),
        .tick  (tick)
    );

    // Work out which digit is shown next and which frame it comes from.
    // A fresh frame is latched both on start-up and on the 3 -> 0 wrap,
    // and blanking is judged against that next digit and next frame so the
    // registered outputs line up with the slot they describe.
    always_comb begin
        next_idx    = idx;
        next_shadow = shadow;
        next_fs     = 1'b0;
        if (state == ST_IDLE) begin
            next_idx    = 2'd0;
            next_shadow = digits;
            next_fs     = 1'b1;
        end else if (tick) begin
            next_idx = idx + 2'd1;
            if (idx == 2'd3) begin
                next_shadow = digits;
                next_fs     = 1'b1;
            end
        end
        next_dark = blank[2'd3 - next_idx] ||
                    (LZ_BLANK && lz_dark(next_shadow, next_idx));
    end

    // Scan state and registered outputs. Reset wins, then a low enable
    // darkens everything and drops back to idle so the next enable starts
    // a clean frame at digit 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            idx         <= 2'd0;
            shadow      <= '0;
            indicador   <= SEL_OFF;
            digit_value <= '0;
            frame_start <= 1'b0;
        end else if (!enable) begin
            state       <= ST_IDLE;
            idx         <= 2'd0;
            indicador   <= SEL_OFF;
            frame_start <= 1'b0;
        end else begin
            state       <= ST_SCAN;
            idx         <= next_idx;
            shadow      <= next_shadow;
            frame_start <= next_fs;
            digit_value <= digit_nibble(next_shadow, next_idx);
            indicador   <= next_dark ? SEL_OFF : SEL[next_idx];
        end
    end

endmodule

// File: tb/tb_display_scan.sv
// tb_display_scan
// Self-checking bench for display_scan. Two instances share the inputs:
// one plain, one with leading-zero suppression. A time-based model
// (elapsed cycles since start-up -> digit slot and frame number) predicts
// every output.
module tb_display_scan;

    localparam int CLK_DIV = 4;
    localparam int FRAME   = 4 * CLK_DIV;

    logic        clk    = 1'b0;
    logic        reset  = 1'b1;
    logic        enable = 1'b0;
    logic [15:0] digits = 16'h0000;
    logic [3:0]  blank  = 4'b0000;

    logic [3:0]  indicador,    digit_value;
    logic        frame_start;
    logic [3:0]  lz_indicador, lz_digit_value;
    logic        lz_frame_start;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    display_scan #(.CLK_DIV(CLK_DIV), .LZ_BLANK(1'b0)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .digits      (digits),
        .blank       (blank),
        .indicador   (indicador),
        .digit_value (digit_value),
        .frame_start (frame_start)
    );

    display_scan #(.CLK_DIV(CLK_DIV), .LZ_BLANK(1'b1)) dut_lz (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .digits      (digits),
        .blank       (blank),
        .indicador   (lz_indicador),
        .digit_value (lz_digit_value),
        .frame_start (lz_frame_start)
    );

    // Reference model: t counts cycles since the start-up edge. The digit
    // on show is (t / CLK_DIV) mod 4, and a new frame is captured whenever
    // t is a multiple of the frame length.
    bit          m_run = 1'b0;
    int          t     = 0;
    int          d     = 0;
    logic [15:0] m_frame  = 16'h0000;
    logic [3:0]  e_ind    = 4'b0000;
    logic [3:0]  e_ind_lz = 4'b0000;
    logic [3:0]  e_val    = 4'b0000;
    logic        e_fs     = 1'b0;
    bit          e_val_valid = 1'b1;

    always @(posedge clk) begin
        if (reset) begin
            m_run = 1'b0; t = 0; m_frame = 16'h0000;
            e_ind = 4'b0000; e_ind_lz = 4'b0000; e_val = 4'b0000;
            e_fs = 1'b0; e_val_valid = 1'b1;
        end else if (!enable) begin
            m_run = 1'b0; t = 0;
            e_ind = 4'b0000; e_ind_lz = 4'b0000; e_fs = 1'b0;
            e_val_valid = 1'b0;
        end else begin
            if (!m_run) begin
                m_run = 1'b1;
                t = 0;
            end else begin
                t++;
            end
            if (t % FRAME == 0) m_frame = digits;
            d = (t / CLK_DIV) % 4;
            e_fs = (t % FRAME == 0);
            e_val = m_frame[4*(3-d) +: 4];
            e_val_valid = 1'b1;
            e_ind = blank[3-d] ? 4'b0000 : (4'b1000 >> d);
            e_ind_lz = (blank[3-d] || (d < 3 && (m_frame >> (4*(3-d))) == 16'h0000))
                       ? 4'b0000 : (4'b1000 >> d);
        end
    end

    // Select vectors must never light two digits at once.
    always @(negedge clk) begin
        if (!reset) begin
            vectors++;
            if (!$onehot0(indicador) || !$onehot0(lz_indicador)) begin
                miscompares++;
                $display("[TB] FAIL onehot at %0t: got %b / %b, need popcount<=1",
                         $time, indicador, lz_indicador);
            end
        end
    end

    task automatic applyStimulus(input logic en, input logic [15:0] dg, input logic [3:0] bl);
        enable = en;
        digits = dg;
        blank  = bl;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        applyStimulus(1'b1, 16'h1234, 4'b0000);
        repeat (3) begin
            @(negedge clk);
            vectors++;
            if (indicador !== 4'b0000 || digit_value !== 4'h0 || frame_start !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL reset_state: got ind=%b val=%h fs=%b want 0000/0/0",
                         indicador, digit_value, frame_start);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_scan();
        applyStimulus(1'b1, 16'h1234, 4'b0000);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            vectors++;
            if (indicador !== e_ind || digit_value !== e_val || frame_start !== e_fs) begin
                miscompares++;
                $display("[TB] FAIL scan cyc %0d: got ind=%b val=%h fs=%b want %b/%h/%b",
                         i, indicador, digit_value, frame_start, e_ind, e_val, e_fs);
            end
        end
    endtask

    task automatic test_midframe();
        int guard;
        guard = 0;
        while (e_ind !== 4'b0100 && guard < 64) begin
            @(negedge clk);
            guard++;
        end
        vectors++;
        if (guard >= 64) begin
            miscompares++;
            $display("[TB] FAIL midframe_wait: got no digit-1 slot, want one within 64 cycles");
        end
        digits = 16'h5678;
        for (int i = 0; i < 36; i++) begin
            @(negedge clk);
            vectors++;
            if (indicador !== e_ind || digit_value !== e_val) begin
                miscompares++;
                $display("[TB] FAIL midframe cyc %0d: got ind=%b val=%h want %b/%h",
                         i, indicador, digit_value, e_ind, e_val);
            end
        end
    endtask

    task automatic test_lz_blank();
        logic [15:0] pats [2];
        pats[0] = 16'h0040;
        pats[1] = 16'h0000;
        for (int p = 0; p < 2; p++) begin
            applyStimulus(1'b1, pats[p], 4'b0000);
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                vectors++;
                if (lz_indicador !== e_ind_lz || lz_digit_value !== e_val) begin
                    miscompares++;
                    $display("[TB] FAIL lz_blank pat=%h cyc %0d: got ind=%b val=%h want %b/%h",
                             pats[p], i, lz_indicador, lz_digit_value, e_ind_lz, e_val);
                end
            end
        end
    endtask

    task automatic test_blank();
        applyStimulus(1'b1, 16'h1234, 4'b0100);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            vectors++;
            if (indicador !== e_ind || lz_indicador !== e_ind_lz || frame_start !== e_fs) begin
                miscompares++;
                $display("[TB] FAIL blank cyc %0d: got ind=%b lz=%b fs=%b want %b/%b/%b",
                         i, indicador, lz_indicador, frame_start, e_ind, e_ind_lz, e_fs);
            end
        end
        blank = 4'b0000;
    endtask

    task automatic test_disable();
        int guard;
        guard = 0;
        while (e_ind !== 4'b0010 && guard < 64) begin
            @(negedge clk);
            guard++;
        end
        vectors++;
        if (guard >= 64) begin
            miscompares++;
            $display("[TB] FAIL disable_wait: got no digit-2 slot, want one within 64 cycles");
        end
        @(negedge clk);
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++;
            if (indicador !== 4'b0000 || frame_start !== 1'b0 || indicador !== e_ind) begin
                miscompares++;
                $display("[TB] FAIL disabled cyc %0d: got ind=%b fs=%b want 0000/0",
                         i, indicador, frame_start);
            end
        end
        applyStimulus(1'b1, 16'h9876, 4'b0000);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            vectors++;
            if (indicador !== e_ind || digit_value !== e_val || frame_start !== e_fs) begin
                miscompares++;
                $display("[TB] FAIL reenable cyc %0d: got ind=%b val=%h fs=%b want %b/%h/%b",
                         i, indicador, digit_value, frame_start, e_ind, e_val, e_fs);
            end
        end
    endtask

    task automatic test_midreset();
        repeat (7) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if (indicador !== 4'b0000 || digit_value !== 4'h0 || frame_start !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL midreset: got ind=%b val=%h fs=%b want 0000/0/0",
                     indicador, digit_value, frame_start);
        end
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            vectors++;
            if (indicador !== e_ind || digit_value !== e_val || frame_start !== e_fs) begin
                miscompares++;
                $display("[TB] FAIL postreset cyc %0d: got ind=%b val=%h fs=%b want %b/%h/%b",
                         i, indicador, digit_value, frame_start, e_ind, e_val, e_fs);
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] mask;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            vectors++;
            if (indicador !== e_ind || lz_indicador !== e_ind_lz || frame_start !== e_fs ||
                (e_val_valid && (digit_value !== e_val || lz_digit_value !== e_val))) begin
                miscompares++;
                $display("[TB] FAIL random cyc %0d: got ind=%b lz=%b fs=%b val=%h want %b/%b/%b/%h",
                         i, indicador, lz_indicador, frame_start, digit_value,
                         e_ind, e_ind_lz, e_fs, e_val);
            end
            mask = 16'hFFFF >> (4 * $urandom_range(0, 4));
            applyStimulus(($urandom_range(0, 19) != 0),
                          16'($urandom) & mask,
                          ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000);
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_midframe();
        test_lz_blank();
        test_blank();
        test_disable();
        test_midreset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
